// File: rtl/mem_subword_ctrl_if.sv
// Request / response / memory-port bundle for mem_subword_ctrl.
// slave  : the controller's view (accepts requests, drives memory port).
// master : the requester + memory model view (drives requests, returns read data).
interface mem_subword_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_subword_ctrl.sv
// Sub-word (byte/half/word) load/store controller in front of a 32-bit
// word memory with one-cycle read latency. Lanes are big-endian.
// Sub-word stores are read-modify-write. Memory port and response
// outputs are registered; req_ready is decoded from the IDLE state.
// Optional build macro MEM_ALIGN_EXC_EN: reject misaligned half/word
// accesses with resp_err instead of ignoring the low address bits.
module mem_subword_ctrl (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_subword_ctrl_if.slave      bus_io
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;

  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        req_ready_s;
  logic        accept_s;
  logic        misalign_s;

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of a memory word with the low store bits.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off,
                                             input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r[31:24] = wdata[7:0];
          2'd1:    r[23:16] = wdata[7:0];
          2'd2:    r[15:8]  = wdata[7:0];
          default: r[7:0]   = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[15:0]  = wdata[15:0];
        else        r[31:16] = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Ready only in IDLE and never while reset is held.
  assign req_ready_s = (state_q == IDLE) && rst_n;
  assign accept_s    = bus_io.req_valid && req_ready_s;

`ifdef MEM_ALIGN_EXC_EN
  assign misalign_s = ((bus_io.req_size == 2'b01) && bus_io.req_addr[0]) ||
                      ((bus_io.req_size == 2'b10) && (bus_io.req_addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  // Next-state and next-output decode; outputs are pulses unless set here.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          we_d       = bus_io.req_we;
          size_d     = bus_io.req_size;
          sgn_d      = bus_io.req_signed;
          off_d      = bus_io.req_addr[1:0];
          wdata_d    = bus_io.req_wdata;
          mem_addr_d = bus_io.req_addr[31:2];
          if ((bus_io.req_size == 2'b11) || misalign_s) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (bus_io.req_we && (bus_io.req_size == 2'b10)) begin
            state_d     = WRITE;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = bus_io.req_wdata;
          end else begin
            state_d  = READ;
            mem_en_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (we_q) begin
          state_d     = WRITE;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_wdata_d = merge_lane(bus_io.mem_rdata, size_q, off_q, wdata_q);
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = extract_lane(bus_io.mem_rdata, size_q, off_q, sgn_q);
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured request fields and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0000_0000;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 30'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus_io.req_ready  = req_ready_s;
  assign bus_io.resp_valid = resp_valid_q;
  assign bus_io.resp_err   = resp_err_q;
  assign bus_io.resp_rdata = resp_rdata_q;
  assign bus_io.mem_en     = mem_en_q;
  assign bus_io.mem_we     = mem_we_q;
  assign bus_io.mem_addr   = mem_addr_q;
  assign bus_io.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_subword_ctrl.sv
// Directed bench for mem_subword_ctrl with a one-cycle-latency word memory.
module tb_mem_subword_ctrl;

  logic clk;
  logic rst_n;

  mem_subword_ctrl_if bus_if ();

  mem_subword_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: 64 words, read data valid the cycle after the read.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (bus_if.mem_en && bus_if.mem_we)
      mem[bus_if.mem_addr[5:0]] <= bus_if.mem_wdata;
    if (bus_if.mem_en && !bus_if.mem_we)
      bus_if.mem_rdata <= mem[bus_if.mem_addr[5:0]];
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat, n_rd, n_wr, rd_k, wr_k, bad_evt;
  logic [31:0] r_rdata, wr_data;
  logic        r_err;
  logic [29:0] wr_addr, rd_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, watch the memory port and response for a bounded time.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
    lat = -1; n_rd = 0; n_wr = 0; rd_k = -1; wr_k = -1;
    r_rdata = 32'h0; r_err = 1'b0; wr_data = 32'h0; wr_addr = 30'h0; rd_addr = 30'h0;
    @(negedge clk);
    bus_if.req_valid  = 1'b1;
    bus_if.req_we     = we;
    bus_if.req_size   = size;
    bus_if.req_signed = sgn;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    #1;
    check("ready_at_req", {31'd0, bus_if.req_ready}, 32'd1);
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      if (k == 1 && !bus_if.resp_valid)
        check("busy_not_ready", {31'd0, bus_if.req_ready}, 32'd0);
      if (bus_if.mem_en) begin
        if (bus_if.mem_we) begin
          n_wr++; wr_k = k; wr_addr = bus_if.mem_addr; wr_data = bus_if.mem_wdata;
        end else begin
          n_rd++; rd_k = k; rd_addr = bus_if.mem_addr;
        end
      end
      if (bus_if.resp_valid) begin
        lat = k; r_rdata = bus_if.resp_rdata; r_err = bus_if.resp_err;
      end
    end
    @(negedge clk);
    check("resp_one_cycle", {31'd0, bus_if.resp_valid}, 32'd0);
    check("ready_after_resp", {31'd0, bus_if.req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_size = 2'b00;
    bus_if.req_signed = 1'b0; bus_if.req_addr = 32'h0; bus_if.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    // reset state
    check("rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
    check("rst_resp_err",   {31'd0, bus_if.resp_err},   32'd0);
    check("rst_resp_rdata", bus_if.resp_rdata, 32'h0);
    check("rst_mem_en",     {31'd0, bus_if.mem_en},     32'd0);
    check("rst_mem_we",     {31'd0, bus_if.mem_we},     32'd0);
    check("rst_mem_wdata",  bus_if.mem_wdata, 32'h0);
    check("rst_mem_addr",   {2'b00, bus_if.mem_addr}, 32'h0);
    check("rst_req_ready",  {31'd0, bus_if.req_ready},  32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", {31'd0, bus_if.req_ready}, 32'd1);

    // preset word 0x10 with a word store
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hA1B2_C3D4);
    check("preset_lat", 32'(lat), 32'd2);
    check("preset_wr_addr", {2'b00, wr_addr}, 32'h4);
    check("preset_n_rd", 32'(n_rd), 32'd0);

    // signed byte load offset 1
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0);
    check("lb_s_lat", 32'(lat), 32'd3);
    check("lb_s_data", r_rdata, 32'hFFFF_FFB2);
    check("lb_s_err", {31'd0, r_err}, 32'd0);
    check("lb_s_n_rd", 32'(n_rd), 32'd1);
    check("lb_s_rd_addr", {2'b00, rd_addr}, 32'h4);
    check("lb_s_n_wr", 32'(n_wr), 32'd0);

    // byte store offset 3 (read-modify-write)
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_005A);
    check("sb_lat", 32'(lat), 32'd4);
    check("sb_rd_k", 32'(rd_k), 32'd1);
    check("sb_wr_k", 32'(wr_k), 32'd3);
    check("sb_wr_data", wr_data, 32'hA1B2_C35A);
    check("sb_wr_addr", {2'b00, wr_addr}, 32'h4);
    check("sb_rdata", r_rdata, 32'h0);

    // unsigned byte loads: offset 3 sees the stored byte, offset 0 the MSB
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
    check("lbu3_data", r_rdata, 32'h0000_005A);
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0);
    check("lbu0_data", r_rdata, 32'h0000_00A1);

    // half loads of 0x8001FFFE
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h8001_FFFE);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0);
    check("lhu2_data", r_rdata, 32'h0000_FFFE);
    check("lhu2_lat", 32'(lat), 32'd3);
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0);
    check("lh0_s_data", r_rdata, 32'hFFFF_8001);

    // half store uses only low 16 bits of wdata
    do_req(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'hFFFF_1234);
    check("sh_wr_data", wr_data, 32'h8001_1234);
    check("sh_lat", 32'(lat), 32'd4);

    // word store 0xDEADBEEF to 0x20
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_wr_k", 32'(wr_k), 32'd1);
    check("sw_wr_addr", {2'b00, wr_addr}, 32'h8);
    check("sw_n_wr", 32'(n_wr), 32'd1);
    check("sw_rdata", r_rdata, 32'h0);

    // reserved size
    do_req(1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0);
    check("rsv_lat", 32'(lat), 32'd1);
    check("rsv_err", {31'd0, r_err}, 32'd1);
    check("rsv_mem_cycles", 32'(n_rd + n_wr), 32'd0);
    check("rsv_rdata", r_rdata, 32'h0);

    // misaligned half 0x11 and word 0x22
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0);
`ifdef MEM_ALIGN_EXC_EN
    check("mis_h_lat", 32'(lat), 32'd1);
    check("mis_h_err", {31'd0, r_err}, 32'd1);
    check("mis_h_mem", 32'(n_rd + n_wr), 32'd0);
`else
    check("mis_h_lat", 32'(lat), 32'd3);
    check("mis_h_err", {31'd0, r_err}, 32'd0);
    check("mis_h_data", r_rdata, 32'h0000_8001);
`endif
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0022, 32'h0);
`ifdef MEM_ALIGN_EXC_EN
    check("mis_w_err", {31'd0, r_err}, 32'd1);
    check("mis_w_mem", 32'(n_rd + n_wr), 32'd0);
`else
    check("mis_w_err", {31'd0, r_err}, 32'd0);
    check("mis_w_data", r_rdata, 32'hDEAD_BEEF);
`endif

    // reset while a byte store sits in WAIT
    @(negedge clk);
    bus_if.req_valid = 1'b1; bus_if.req_we = 1'b1; bus_if.req_size = 2'b00;
    bus_if.req_signed = 1'b0; bus_if.req_addr = 32'h0000_0010; bus_if.req_wdata = 32'h0000_0077;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    check("mid_read_issued", {31'd0, bus_if.mem_en}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, bus_if.req_ready}, 32'd0);
    check("mid_rst_mem_en", {31'd0, bus_if.mem_en}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid_release_ready", {31'd0, bus_if.req_ready}, 32'd1);
    bad_evt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.resp_valid || bus_if.mem_en) bad_evt++;
    end
    check("mid_abandoned", 32'(bad_evt), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    check("mid_word_intact", r_rdata, 32'h8001_1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_subword_ctrl.md
MEM_SUBWORD_CTRL -- requirements
Module: mem_subword_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk input 1 (all state on rising edge); rst_n input 1 (sync reset, active low).
REQ-002 SHALL have ports req_valid input 1 (request present); req_ready output 1 (accepting); req_we input 1 (1 store, 0 load); req_size input 2 (00 byte, 01 half, 10 word, 11 reserved); req_signed input 1 (sign-extend load); req_addr input 32 (byte address); req_wdata input 32 (store data, right-aligned).
REQ-003 SHALL have ports resp_valid output 1 (one-cycle completion pulse); resp_rdata output 32 (load result, right-aligned); resp_err output 1 (access rejected).
REQ-004 SHALL have ports mem_en output 1 (memory cycle); mem_we output 1 (write); mem_addr output 30 (word address = addr[31:2]); mem_wdata output 32; mem_rdata input 32 (valid the cycle after a read is issued).

Function
REQ-005 SHALL use big-endian lanes: byte offset 0 = bits 31:24, offset 3 = bits 7:0; half offset 0 = bits 31:16, offset 2 = bits 15:0.
REQ-006 SHALL use FSM states IDLE, READ, WAIT, WRITE, RESP; req_ready = 1 only in IDLE; request accepted on req_valid && req_ready, all request fields registered at that edge.
REQ-007 On accept (cycle T) SHALL go: load -> READ; byte/half store -> READ; word store -> WRITE; reserved size -> RESP with error.
REQ-008 READ SHALL drive mem_en=1, mem_we=0, mem_addr from registered address, then go WAIT.
REQ-009 WAIT SHALL sample mem_rdata: load -> extract lane, zero- or sign-extend per req_signed, register result, go RESP; sub-word store -> register mem_rdata with store lane replaced by low bits of req_wdata, other lanes unchanged, go WRITE.
REQ-010 WRITE SHALL drive mem_en=1, mem_we=1, mem_wdata = merged word (sub-word) or req_wdata (word), then go RESP.
REQ-011 RESP SHALL assert resp_valid for exactly one cycle, then go IDLE; no response back-pressure.
REQ-012 Latency accept->resp_valid SHALL be: load T+3, word store T+2, sub-word store T+4, rejected T+1.
REQ-013 resp_rdata SHALL be 0 for stores and rejected accesses; resp_err SHALL be 0 except as in REQ-014/REQ-019; both stable only while resp_valid=1 is required.
REQ-014 Reserved size 2'b11 SHALL set resp_err=1 with no memory cycle, regardless of configuration.
REQ-015 mem_en SHALL be 0 in IDLE, WAIT, RESP; mem_we SHALL be 0 whenever mem_en=0.
REQ-016 A new request SHALL be accepted no earlier than the cycle after resp_valid (back-to-back: resp in cycle N, next accept in N+1).

Reset
REQ-017 rst_n=0 at a clock edge SHALL force IDLE and clear all registered fields; after that edge resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_wdata, mem_addr = 0 and req_ready = 0 while rst_n=0, 1 in the first cycle with rst_n=1.
REQ-018 Reset mid-operation SHALL abandon the access: no pending write issued, no resp_valid for it.

Configuration
REQ-019 Macro MEM_ALIGN_EXC_EN: defined -> half with addr[0]=1 or word with addr[1:0]!=0 takes no memory cycle, responds at T+1 with resp_err=1; undefined -> address low bits ignored (half uses addr[1] only, word forced aligned), misalignment never flags resp_err.

Verification
REQ-020 Word @0x10=0xA1B2C3D4 preset; load byte signed addr 0x11 -> resp_rdata 0xFFFFFFB2 at T+3, one mem read at word 0x4.
REQ-021 Same word; store byte 0x5A to 0x13 -> read T+1, write T+3 mem_wdata 0xA1B2C35A, resp_valid T+4, resp_rdata 0.
REQ-022 Load half unsigned 0x12 of 0x8001FFFE -> 0x0000FFFE; signed 0x10 -> 0xFFFF8001.
REQ-023 Store word 0xDEADBEEF to 0x20 -> single write T+1 mem_addr 0x8, resp_valid T+2; size 11 -> resp_err=1 at T+1, mem_en never 1.
REQ-024 Load half 0x11: with MEM_ALIGN_EXC_EN resp_err=1 at T+1, no mem_en; without, returns half at offset 0, resp_err=0.
REQ-025 rst_n=0 in WAIT of sub-word store -> no write cycle, no resp_valid, req_ready=1 first cycle after release.
